register_file: RTL and testbench

//   Multi-entry general-purpose register file for the 8-bit CPU datapath.

---
 rtl/register_file.sv | 119 +++++++++++
 tb/tb_register_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Purpose:
//   General-purpose register file for the 8-bit CPU datapath. It has one
//   write port and two read ports. Both read ports are registered on the
//   rising edge of CLK, so OUT1/OUT2 are already stable when the downstream
//   negedge-clocked operand mux samples them.
//
// Ports:
//   CLK          in   1           clock; all state updates on posedge
//   RESET        in   1           synchronous reset, active-high
//   WRITE        in   1           write enable for this cycle
//   INADDRESS    in   ADDR_WIDTH  write address
//   IN           in   DATA_WIDTH  write data
//   OUT1ADDRESS  in   ADDR_WIDTH  read port 1 address
//   OUT2ADDRESS  in   ADDR_WIDTH  read port 2 address
//   OUT1         out  DATA_WIDTH  read port 1 data, registered
//   OUT2         out  DATA_WIDTH  read port 2 data, registered
//
// Configuration macro:
//   REGFILE_ZERO_REG_EN
//     Defined:   register 0 always reads as zero, and writes to it are dropped.
//                This includes the same-cycle bypass path.
//     Undefined: register 0 behaves like every other register.
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] out1_q;
    logic [DATA_WIDTH-1:0] out1_d;
    logic [DATA_WIDTH-1:0] out2_q;
    logic [DATA_WIDTH-1:0] out2_d;
    logic                  wr_en_s;

    // Read data for one port. A write to the same address in the same cycle
    // forwards the new data, so a port never returns the stale array value.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] raddr,
        input logic                  wr,
        input logic [ADDR_WIDTH-1:0] waddr,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] data;
        if (wr && (waddr == raddr)) begin
            data = wdata;
        end else begin
            data = stored;
        end
`ifdef REGFILE_ZERO_REG_EN
        // The hardwired zero register wins over the bypass.
        if (raddr == {ADDR_WIDTH{1'b0}}) begin
            data = {DATA_WIDTH{1'b0}};
        end else begin
            data = data;
        end
`endif
        return data;
    endfunction

    // Effective write enable. With the zero register enabled, writes to
    // address 0 are discarded.
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_en_s = WRITE && (INADDRESS != {ADDR_WIDTH{1'b0}});
`else
        wr_en_s = WRITE;
`endif
    end

    // Next-state for the array and both registered read ports.
    always_comb begin
        regs_d = regs_q;
        out1_d = read_port(OUT1ADDRESS, WRITE, INADDRESS, IN, regs_q[OUT1ADDRESS]);
        out2_d = read_port(OUT2ADDRESS, WRITE, INADDRESS, IN, regs_q[OUT2ADDRESS]);
        if (wr_en_s) begin
            regs_d[INADDRESS] = IN;
        end else begin
            regs_d[INADDRESS] = regs_q[INADDRESS];
        end
    end

    // State registers. A synchronous reset clears the array and outputs and
    // drops any write presented in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_WIDTH{1'b0}};
            end
            out1_q <= {DATA_WIDTH{1'b0}};
            out2_q <= {DATA_WIDTH{1'b0}};
        end else begin
            regs_q <= regs_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
        end
    end

    assign OUT1 = out1_q;
    assign OUT2 = out2_q;

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Directed, self-checking bench for register_file. Every driven cycle pushes
// its expected read data to a scoreboard queue. The queue is popped and
// compared one posedge later, when the registered outputs are valid.
// Expected data comes from a behavioural memory image that the bench keeps.
// Honours REGFILE_ZERO_REG_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_register_file;

    localparam int DW = 8;
    localparam int AW = 3;
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          write;
    logic [AW-1:0] inaddress;
    logic [DW-1:0] in_data;
    logic [AW-1:0] out1address;
    logic [AW-1:0] out2address;
    logic [DW-1:0] out1;
    logic [DW-1:0] out2;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] exp1_q [$];
    logic [DW-1:0] exp2_q [$];
    string         tag_q  [$];
    logic [DW-1:0] last1;
    logic [DW-1:0] last2;

    // Downstream model: the two's-complement negator plus the
    // negedge-clocked operand mux.
    logic          mux_select;
    logic [DW-1:0] mux_out;

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .WRITE       (write),
        .INADDRESS   (inaddress),
        .IN          (in_data),
        .OUT1ADDRESS (out1address),
        .OUT2ADDRESS (out2address),
        .OUT1        (out1),
        .OUT2        (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        mux_out <= mux_select ? (~out2 + 8'd1) : out2;
    end

    // Hard time limit so that the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra, input logic wr,
                                                  input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (ZERO_EN && ra == 3'd0) return 8'h00;
        if (wr && wa == ra) return wd;
        return mem[ra];
    endfunction

    // One clock of stimulus: drive at negedge, predict, then compare after the posedge.
    task automatic step(input string tag, input logic rst, input logic wr, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        string         t;
        @(negedge clk);
        reset = rst; write = wr; inaddress = wa; in_data = wd;
        out1address = a1; out2address = a2;
        if (rst) begin
            e1 = 8'h00; e2 = 8'h00;
            for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        end else begin
            e1 = model_read(a1, wr, wa, wd);
            e2 = model_read(a2, wr, wa, wd);
            if (wr && !(ZERO_EN && wa == 3'd0)) mem[wa] = wd;
        end
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp1_q.size() == 0) begin
            check("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            t = tag_q.pop_front();
            last1 = exp1_q.pop_front();
            last2 = exp2_q.pop_front();
            check({t, "_out1"}, out1, last1);
            check({t, "_out2"}, out2, last2);
        end
    endtask

    initial begin
        reset = 1'b1; write = 1'b0; inaddress = 3'd0; in_data = 8'h00;
        out1address = 3'd0; out2address = 3'd0; mux_select = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset state, with a write presented during reset.
        step("reset", 1'b1, 1'b1, 3'd6, 8'h99, 3'd0, 3'd6);
        step("post_reset_rd", 1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd0);

        // Test 1: preload registers 1..7, read them back, reset, then everything reads 0.
        for (int i = 1; i < 8; i++) step("preload", 1'b0, 1'b1, AW'(i), DW'(i * 16 + i), 3'd0, 3'd0);
        for (int i = 1; i < 8; i++) step("preload_rd", 1'b0, 1'b0, 3'd0, 8'h00, AW'(i), AW'(8 - i));
        step("reset_clear", 1'b1, 1'b0, 3'd0, 8'h00, 3'd7, 3'd1);
        for (int i = 0; i < 8; i++) step("cleared_rd", 1'b0, 1'b0, 3'd0, 8'h00, AW'(i), AW'(7 - i));

        // Test 2: write and read back on both ports, then hold across the negedge.
        step("wr3", 1'b0, 1'b1, 3'd3, 8'h2A, 3'd0, 3'd1);
        step("rd3", 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3);
        check("rd3_const_out1", last1, 8'h2A);
        @(negedge clk);
        #1;
        check("rd3_hold_out1", out1, 8'h2A);
        check("rd3_hold_out2", out2, 8'h2A);

        // Test 3: read-during-write bypass on port 1 while port 2 reads register 4.
        step("wr5", 1'b0, 1'b1, 3'd5, 8'h11, 3'd0, 3'd0);
        step("wr4", 1'b0, 1'b1, 3'd4, 8'h44, 3'd5, 3'd0);
        step("bypass", 1'b0, 1'b1, 3'd5, 8'h77, 3'd5, 3'd4);
        check("bypass_const", last1, 8'h77);
        step("bypass_after", 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd5);
        step("bypass_both", 1'b0, 1'b1, 3'd6, 8'hC3, 3'd6, 3'd6);

        // Test 4: reset beats a same-cycle write.
        step("rst_vs_wr", 1'b1, 1'b1, 3'd2, 8'hFF, 3'd2, 3'd2);
        step("rst_vs_wr_rd", 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2);

        // Test 5: OUT2 feeds the negator and the mux (SELECT=1). -2 is 8'hFE.
        step("wr1", 1'b0, 1'b1, 3'd1, 8'h02, 3'd0, 3'd0);
        step("rd1", 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd1);
        @(negedge clk);
        #1;
        check("mux_neg", mux_out, 8'hFE);

        // Test 6: register 0, whose result depends on REGFILE_ZERO_REG_EN.
        step("wr0", 1'b0, 1'b1, 3'd0, 8'h55, 3'd1, 3'd0);
        step("rd0", 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        check("rd0_const", last1, ZERO_EN ? 8'h00 : 8'h55);
        step("wr0_bypass", 1'b0, 1'b1, 3'd0, 8'hAA, 3'd0, 3'd1);
        check("wr0_bypass_const", last1, ZERO_EN ? 8'h00 : 8'hAA);

        // Random traffic against the memory model.
        for (int n = 0; n < 60; n++) begin
            step("rand", ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
